imem_program_loader: RTL and testbench

//  Byte-serial writer for the instruction memory. It streams a program into the imem write port while holding the core in reset.
//  It assembles big-endian bytes into 32-bit words and writes them at sequential word addresses from 0.

---
 rtl/imem_program_loader_if.sv | 22 ++
 rtl/imem_program_loader.sv | 188 ++++++++++++++++++
 tb/tb_imem_program_loader.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_program_loader_if.sv
// Host byte stream plus imem write port of the program loader.
// master = host/testbench side, slave = loader side.
interface imem_program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_program_loader.sv
// Streams a length-prefixed, big-endian byte image into imem while holding the core in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over the data bytes.
//
// state   | meaning
// IDLE    | waiting for Start, core held in reset
// LEN_HI  | expecting word-count high byte
// LEN_LO  | expecting word-count low byte, range-checked against capacity
// DATA    | assembling bytes into words and writing them
// CHECK   | expecting checksum byte (LOADER_CHECKSUM_EN only)
// DONE    | image loaded, core released
// ERROR   | load aborted, core held in reset
module imem_program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  imem_program_loader_if.slave  bus,
  output logic                  cpu_reset_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH:0]   words_written_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  state_e                state_q;
  logic [15:0]           len_q;
  logic [23:0]           asm_q;
  logic [1:0]            byte_cnt_q;
  logic                  last_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [31:0]           wr_data_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic                  cpu_reset_q;
  logic                  done_q;
  logic                  error_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            chk_q;
`endif

  logic        in_ready;
  logic        hs;
  logic [15:0] len_d;
  logic [31:0] word_d;
  logic        last_word_d;

  // last_q closes the byte window once the final word is assembled, so a
  // trailing byte is not taken while that word is still being written.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO: in_ready = 1'b1;
      S_DATA:             in_ready = !last_q;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:            in_ready = 1'b1;
`endif
      default:            in_ready = 1'b0;
    endcase
  end

  assign hs          = bus.in_valid & in_ready;
  assign len_d       = {len_q[15:8], bus.in_data};
  assign word_d      = {asm_q, bus.in_data};
  assign last_word_d = ({1'b0, len_q} == (17'(words_q) + 17'd1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      asm_q       <= '0;
      byte_cnt_q  <= '0;
      last_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      words_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state_q     <= S_LEN_HI;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= '0;
            wr_addr_q   <= '0;
            cpu_reset_q <= 1'b1;
            byte_cnt_q  <= '0;
            last_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (hs) begin
            len_q[15:8] <= bus.in_data;
            state_q     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (hs) begin
            len_q[7:0] <= bus.in_data;
            if ((len_d == 16'd0) || ({1'b0, len_d} > CAP)) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (hs) begin
            asm_q      <= word_d[23:0];
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= chk_q ^ bus.in_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= word_d;
              if (last_word_d) last_q <= 1'b1;
            end
          end
          // Address saturates at the top word so a full-capacity load never wraps.
          if (wr_en_q) begin
            words_q <= words_q + (ADDR_WIDTH+1)'(1);
            if (wr_addr_q != '1) wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
            if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= S_CHECK;
`else
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (hs) begin
            if (bus.in_data == chk_q) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign cpu_reset_o     = cpu_reset_q;
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign words_written_o = words_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: byte-stream reference model checked every cycle,
// plus directed loads with literal expectations. Honours LOADER_CHECKSUM_EN.
module tb_imem_program_loader;
  localparam int AW  = 8;
  localparam int CAP = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
  localparam int CHKB = 1;
`else
  localparam int CHKB = 0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          cpu_reset_o, done_o, error_o;
  logic [AW:0]   words_written_o;

  imem_program_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .bus             (bus),
    .cpu_reset_o     (cpu_reset_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .words_written_o (words_written_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model (byte-stream level) ----------------
  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t         exp_q[$];
  bit          m_active, m_done, m_err, m_cpurst, m_wr_now, m_wr_last;
  int          m_rx, m_n, m_words, m_addr, need;
  logic [7:0]  m_nhi, m_acc;
  logic [31:0] m_asm, m_wdata;
  bit          p_rst = 1'b1, p_start = 1'b0, p_hs = 1'b0, act_b, exp_rdy;
  logic [7:0]  p_byte = '0;
  int          wr_seen = 0;
  int          last_wr_addr = 0;
  logic [31:0] last_wr_data = '0;
  wr_t         e;

  always @(negedge clk_i) begin
    // bring the model up to date with what the last rising edge consumed
    if (p_rst) begin
      m_active = 0; m_done = 0; m_err = 0; m_cpurst = 1; m_wr_now = 0; m_wr_last = 0;
      m_rx = 0; m_n = 0; m_words = 0; m_addr = 0; m_wdata = '0; m_asm = '0; m_acc = '0;
      exp_q.delete();
    end else begin
      act_b = m_active;
      if (m_wr_now) begin
        m_words++;
        m_addr = (m_words < CAP) ? m_words : CAP - 1;
        if (m_wr_last && CHKB == 0) begin m_done = 1; m_cpurst = 0; m_active = 0; end
      end
      m_wr_now = 0;
      if (p_start && !act_b) begin
        m_active = 1; m_rx = 0; m_done = 0; m_err = 0; m_words = 0; m_addr = 0;
        m_cpurst = 1; m_acc = '0; m_wr_last = 0;
      end
      if (p_hs) begin
        m_rx++;
        if (m_rx == 1) m_nhi = p_byte;
        else if (m_rx == 2) begin
          m_n = int'({m_nhi, p_byte});
          if (m_n == 0 || m_n > CAP) begin m_err = 1; m_active = 0; end
        end else if (m_rx <= 2 + 4 * m_n) begin
          m_acc ^= p_byte;
          m_asm = {m_asm[23:0], p_byte};
          if ((m_rx - 2) % 4 == 0) begin
            m_wr_now  = 1;
            m_wr_last = (m_rx == 2 + 4 * m_n);
            m_wdata   = m_asm;
            exp_q.push_back('{addr: (m_rx - 2) / 4 - 1, data: m_asm});
          end
        end else begin
          if (p_byte == m_acc) begin m_done = 1; m_cpurst = 0; end
          else m_err = 1;
          m_active = 0;
        end
      end
    end

    chk("wr_en", bus.wr_en, m_wr_now);
    if (bus.wr_en) begin
      wr_seen++;
      last_wr_addr = int'(bus.wr_addr);
      last_wr_data = bus.wr_data;
    end
    if (m_wr_now) begin
      if (exp_q.size() == 0) chk("wr_queue_empty", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.wr_addr, e.addr);
        chk("wr_data", bus.wr_data, e.data);
      end
    end else begin
      chk("wr_addr_idle", bus.wr_addr, m_addr);
      chk("wr_data_hold", bus.wr_data, m_wdata);
    end
    need    = (m_rx >= 2) ? 2 + 4 * m_n + CHKB : 1 << 30;
    exp_rdy = m_active && (m_rx < need) && !(m_wr_now && m_wr_last);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("done", done_o, m_done);
    chk("error", error_o, m_err);
    chk("excl", done_o & error_o, 0);
    chk("cpu_reset", cpu_reset_o, m_cpurst);
    chk("words_written", words_written_o, m_words);

    p_rst   = rst_i;
    p_start = start_i;
    p_hs    = bus.in_valid && bus.in_ready;
    p_byte  = bus.in_data;
  end

  // ---------------- stimulus ----------------
  logic [7:0] strm[$];
  int         cyc_used;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic idle_cycles(input int k, input bit hold_valid);
    bus.in_valid = hold_valid;
    bus.in_data  = 8'($urandom);
    repeat (k) tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bytes(input int gap_pct, input bit rand_start);
    int  budget;
    bit  hs;
    cyc_used = 0;
    foreach (strm[i]) begin
      budget = 0;
      forever begin
        bus.in_valid = ($urandom_range(99) >= gap_pct);
        bus.in_data  = bus.in_valid ? strm[i] : 8'($urandom);
        if (rand_start) start_i = ($urandom_range(7) == 0);
        @(negedge clk_i);
        hs = bus.in_valid && bus.in_ready;
        tick();
        cyc_used++;
        if (hs) break;
        budget++;
        if (budget > 60) begin
          checks++; failures++;
          $display("FAIL stream_stall byte=%0d got=not_accepted want=accepted", i);
          bus.in_valid = 1'b0; start_i = 1'b0;
          return;
        end
      end
    end
    bus.in_valid = 1'b0;
    start_i = 1'b0;
  endtask

  // Header + random words (only when N is in range) + checksum when enabled.
  task automatic make_stream(input int n, input bit bad_chk);
    logic [7:0] acc, b;
    strm.delete();
    strm.push_back(8'(n >> 8));
    strm.push_back(8'(n));
    acc = '0;
    if (n >= 1 && n <= CAP) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        acc ^= b;
        strm.push_back(b);
      end
      if (CHKB == 1) strm.push_back(bad_chk ? (acc ^ 8'(1 + $urandom_range(254))) : acc);
    end
  endtask

  task automatic run_load(input int n, input int gap, input bit rs, input bit bad_chk);
    int w0;
    bit ok;
    w0 = wr_seen;
    ok = (n >= 1 && n <= CAP) && !(bad_chk && CHKB == 1);
    pulse_start();
    chk("start_cpu_reset", cpu_reset_o, 1);
    make_stream(n, bad_chk);
    send_bytes(gap, rs);
    idle_cycles(4, 1'b1);
    chk("load_done", done_o, ok);
    chk("load_error", error_o, !ok);
    chk("load_wr_count", wr_seen - w0, (n >= 1 && n <= CAP) ? n : 0);
  endtask

  initial begin
    int w0, n;
    bit bad;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    chk("rst_cpu_reset", cpu_reset_o, 1);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_words", words_written_o, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    tick();

    // single word DEADBEEF
    w0 = wr_seen;
    pulse_start();
    strm = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    if (CHKB == 1) strm.push_back(8'h22);
    send_bytes(0, 1'b0);
    idle_cycles(4, 1'b1);
    chk("t1_wr_count", wr_seen - w0, 1);
    chk("t1_wr_addr", last_wr_addr, 0);
    chk("t1_wr_data", last_wr_data, 32'hDEADBEEF);
    chk("t1_done", done_o, 1);
    chk("t1_cpu_reset", cpu_reset_o, 0);
    chk("t1_words", words_written_o, 1);

    // N=3 at full rate: one byte per cycle, one pause before the checksum byte
    w0 = wr_seen;
    pulse_start();
    chk("t2_cpu_reset_reassert", cpu_reset_o, 1);
    make_stream(3, 1'b0);
    send_bytes(0, 1'b0);
    chk("t2_stream_cycles", cyc_used, 14 + 2 * CHKB);
    idle_cycles(4, 1'b0);
    chk("t2_wr_count", wr_seen - w0, 3);
    chk("t2_done", done_o, 1);

    // length out of range
    run_load(0, 0, 1'b0, 1'b0);
    chk("t3a_cpu_reset", cpu_reset_o, 1);
    run_load(257, 0, 1'b0, 1'b0);
    chk("t3b_cpu_reset", cpu_reset_o, 1);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    strm = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_bytes(0, 1'b0);
    idle_cycles(3, 1'b0);
    chk("t4_error", error_o, 1);
    chk("t4_cpu_reset", cpu_reset_o, 1);
    pulse_start();
    strm = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_bytes(0, 1'b0);
    idle_cycles(3, 1'b0);
    chk("t4_done", done_o, 1);
`endif

    // reset after 6 data bytes of N=2
    w0 = wr_seen;
    pulse_start();
    make_stream(2, 1'b0);
    strm = strm[0:7];
    send_bytes(0, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t5_wr_count", wr_seen - w0, 1);
    chk("t5_in_ready", bus.in_ready, 0);
    chk("t5_wr_addr", bus.wr_addr, 0);
    chk("t5_words", words_written_o, 0);
    tick();
    run_load(2, 0, 1'b0, 1'b0);

    // randomized loads with gaps and ignored Start pulses
    for (int k = 0; k < 12; k++) begin
      n   = $urandom_range(1, 6);
      bad = ($urandom_range(3) == 0);
      run_load(n, 30, 1'b1, bad);
    end

    // full capacity, final word at top address
    run_load(CAP, 0, 1'b0, 1'b0);
    chk("max_words", words_written_o, CAP);
    chk("max_last_addr", last_wr_addr, CAP - 1);
    chk("max_wr_addr", bus.wr_addr, CAP - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
